booth_div_seq: RTL

//  Sequential signed divider; the inverse of the booth_mult multiply datapath.

---
 rtl/booth_div_seq.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/booth_div_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock,
// with sign fix-up, quotient saturation on overflow and a start/done handshake.
module booth_div_seq #(
    parameter int D_IN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2*D_IN-1:0] dividend,
    input  logic [D_IN-1:0]   divisor,
    output logic              ready,
    output logic              done,
    output logic [D_IN-1:0]   quotient,
    output logic [D_IN-1:0]   remainder,
    output logic              div_by_zero,
    output logic              overflow,
    output logic [31:0]       count
);

    localparam int DW = 2 * D_IN;
    localparam int IW = $clog2(DW);
    localparam logic [DW-1:0] Q_POS_MAX = DW'((1 << (D_IN - 1)) - 1);
    localparam logic [DW-1:0] Q_NEG_MAX = DW'(1 << (D_IN - 1));

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [DW-1:0]     dvd_r;
    logic [D_IN-1:0]   dvs_r;
    logic [D_IN-1:0]   dvs_mag_r;
    logic [D_IN-1:0]   rem_r;
    logic [DW-1:0]     quo_r;
    logic              sign_q_r, sign_r_r;
    logic [IW-1:0]     iter_r;

    logic [D_IN:0]     rem_sh_s;
    logic              rem_ge_s;
    logic [D_IN-1:0]   rem_nx_s;
    logic [DW-1:0]     quo_nx_s;
    logic [D_IN-1:0]   q_fix_s, r_fix_s;
    logic              ovf_fix_s;

    logic              ready_r, ready_s, done_r, done_s;
    logic [D_IN-1:0]   quotient_r, quotient_s, remainder_r, remainder_s;
    logic              dbz_r, dbz_s, ovf_r, ovf_s;
    logic [31:0]       count_r, count_s;

    // Magnitude of the double-width dividend; the most negative value maps to 2^(DW-1) unsigned.
    function automatic logic [DW-1:0] mag_dividend(input logic [DW-1:0] v);
        if (v[DW-1]) begin
            return ~v + DW'(1);
        end else begin
            return v;
        end
    endfunction

    // Magnitude of the divisor; -2^(D_IN-1) still fits as an unsigned D_IN-bit value.
    function automatic logic [D_IN-1:0] mag_divisor(input logic [D_IN-1:0] v);
        if (v[D_IN-1]) begin
            return ~v + D_IN'(1);
        end else begin
            return v;
        end
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_LOAD;
                else       state_s = S_IDLE;
            end
            S_LOAD: begin
                if (dvs_r == {D_IN{1'b0}}) state_s = S_DONE;
                else                       state_s = S_RUN;
            end
            S_RUN: begin
                if (iter_r == IW'(DW - 1)) state_s = S_FIX;
                else                       state_s = S_RUN;
            end
            S_FIX:   state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // One restoring step; the partial remainder stays below |divisor| <= 2^(D_IN-1).
    always_comb begin
        rem_sh_s = {rem_r, quo_r[DW-1]};
        rem_ge_s = (rem_sh_s >= {1'b0, dvs_mag_r});
        if (rem_ge_s) begin
            rem_nx_s = D_IN'(rem_sh_s - {1'b0, dvs_mag_r});
        end else begin
            rem_nx_s = rem_sh_s[D_IN-1:0];
        end
        quo_nx_s = {quo_r[DW-2:0], rem_ge_s};
    end

    // Sign fix-up with range check; the negative side admits one extra magnitude.
    always_comb begin
        if (sign_q_r) begin
            ovf_fix_s = (quo_r > Q_NEG_MAX);
        end else begin
            ovf_fix_s = (quo_r > Q_POS_MAX);
        end
        if (ovf_fix_s) begin
            if (sign_q_r) q_fix_s = {1'b1, {(D_IN-1){1'b0}}};
            else          q_fix_s = {1'b0, {(D_IN-1){1'b1}}};
        end else if (sign_q_r) begin
            q_fix_s = ~quo_r[D_IN-1:0] + D_IN'(1);
        end else begin
            q_fix_s = quo_r[D_IN-1:0];
        end
        if (sign_r_r) begin
            r_fix_s = ~rem_r + D_IN'(1);
        end else begin
            r_fix_s = rem_r;
        end
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r     <= {DW{1'b0}};
            dvs_r     <= {D_IN{1'b0}};
            dvs_mag_r <= {D_IN{1'b0}};
            rem_r     <= {D_IN{1'b0}};
            quo_r     <= {DW{1'b0}};
            sign_q_r  <= 1'b0;
            sign_r_r  <= 1'b0;
            iter_r    <= {IW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                    end
                end
                S_LOAD: begin
                    dvs_mag_r <= mag_divisor(dvs_r);
                    quo_r     <= mag_dividend(dvd_r);
                    rem_r     <= {D_IN{1'b0}};
                    sign_q_r  <= dvd_r[DW-1] ^ dvs_r[D_IN-1];
                    sign_r_r  <= dvd_r[DW-1];
                    iter_r    <= {IW{1'b0}};
                end
                S_RUN: begin
                    rem_r  <= rem_nx_s;
                    quo_r  <= quo_nx_s;
                    iter_r <= iter_r + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Next values for the registered outputs.
    always_comb begin
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        dbz_s       = dbz_r;
        ovf_s       = ovf_r;
        if (state_s == S_IDLE) ready_s = 1'b1;
        else                   ready_s = 1'b0;
        if (state_s == S_DONE) begin
            done_s  = 1'b1;
            count_s = count_r + 32'd1;
        end else begin
            done_s  = 1'b0;
            count_s = count_r;
        end
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    dbz_s = 1'b0;
                    ovf_s = 1'b0;
                end else begin
                    dbz_s = dbz_r;
                    ovf_s = ovf_r;
                end
            end
            S_LOAD: begin
                if (dvs_r == {D_IN{1'b0}}) begin
                    quotient_s  = {D_IN{1'b1}};
                    remainder_s = dvd_r[D_IN-1:0];
                    dbz_s       = 1'b1;
                    ovf_s       = 1'b0;
                end else begin
                    quotient_s  = quotient_r;
                    remainder_s = remainder_r;
                end
            end
            S_FIX: begin
                quotient_s  = q_fix_s;
                remainder_s = r_fix_s;
                ovf_s       = ovf_fix_s;
                dbz_s       = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            quotient_r  <= {D_IN{1'b0}};
            remainder_r <= {D_IN{1'b0}};
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            count_r     <= 32'd0;
        end else begin
            ready_r     <= ready_s;
            done_r      <= done_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            dbz_r       <= dbz_s;
            ovf_r       <= ovf_s;
            count_r     <= count_s;
        end
    end

    assign ready       = ready_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;
    assign overflow    = ovf_r;
    assign count       = count_r;

endmodule
